// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the carry-segmented pipelined adder.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal configuration: every stage resolves the same whole number of bits.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pa_chunk.sv
// Combinational W-bit ripple-carry adder slice with carry in/out.
module pa_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    logic [W:0] cy;

    always_comb begin
        cy    = '0;
        s_o   = '0;
        cy[0] = c_i;
        for (int i = 0; i < W; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
            cy[i+1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = cy[W];
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: chunk k is resolved in stage k; operand chunks are skewed in,
// result chunks are deskewed out, and the whole pipe advances or freezes together.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf_out
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_w;
    logic [WIDTH-1:0]  sum_w;
    logic [WIDTH-1:0]  b_cond;
    logic              cin_cond;

    assign out_valid = vld_q[STAGES-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign sum_out   = sum_w;
    assign c_out     = cy_w[STAGES-1];

    // Subtraction folds into addition: A + ~B + 1; c_in is ignored then.
    always_comb begin
        b_cond   = (sub_in == OP_ADD) ? b_in : ~b_in;
        cin_cond = (sub_in == OP_SUB) | c_in;
    end

    // Bubbles travel like beats, so the valid chain is a plain gated shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SD = STAGES - k;

        logic [CHUNK-1:0]         a_k;
        logic [CHUNK-1:0]         b_k;
        logic [CHUNK-1:0]         s_k;
        logic                     cin_k;
        logic                     co_k;
        logic                     cy_q;
        logic [SD-1:0][CHUNK-1:0] sd_q;

        if (k == 0) begin : g_head
            assign a_k   = a_in[CHUNK-1:0];
            assign b_k   = b_cond[CHUNK-1:0];
            assign cin_k = cin_cond;
        end else begin : g_skew
            logic [k-1:0][CHUNK-1:0] ad_q;
            logic [k-1:0][CHUNK-1:0] bd_q;

            // Chunk k waits k cycles so it meets the carry from stage k-1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ad_q <= '0;
                    bd_q <= '0;
                end else if (adv) begin
                    ad_q[0] <= a_in[k*CHUNK +: CHUNK];
                    bd_q[0] <= b_cond[k*CHUNK +: CHUNK];
                    for (int i = 1; i < k; i++) begin
                        ad_q[i] <= ad_q[i-1];
                        bd_q[i] <= bd_q[i-1];
                    end
                end
            end

            assign a_k   = ad_q[k-1];
            assign b_k   = bd_q[k-1];
            assign cin_k = cy_w[k-1];
        end

        pa_chunk #(.W(CHUNK)) u_chunk (
            .a_i (a_k),
            .b_i (b_k),
            .c_i (cin_k),
            .s_o (s_k),
            .c_o (co_k)
        );

        // Partial sum is registered here, then held back until the last chunk lands.
        always_ff @(posedge clk) begin
            if (rst) begin
                sd_q <= '0;
                cy_q <= 1'b0;
            end else if (adv) begin
                sd_q[0] <= s_k;
                cy_q    <= co_k;
                for (int i = 1; i < SD; i++) sd_q[i] <= sd_q[i-1];
            end
        end

        assign cy_w[k]                   = cy_q;
        assign sum_w[k*CHUNK +: CHUNK]   = sd_q[SD-1];

        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_k[CHUNK-1] == b_k[CHUNK-1]) & (s_k[CHUNK-1] != a_k[CHUNK-1]);
                end
            end

            assign ovf_out = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed checks on an 8-bit/2-stage adder plus randomized scoreboard runs at 32 bits
// with 1, 4 and 8 stages.
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int fails    = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- directed DUT: WIDTH=8, STAGES=2 ----------------
    logic       d_rst = 1'b1, d_iv = 1'b0, d_ir, d_ci = 1'b0, d_sb = 1'b0;
    logic       d_or = 1'b0, d_ov, d_co, d_ovf;
    logic [7:0] d_a = '0, d_b = '0, d_s;

    pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst       (d_rst),
        .in_valid  (d_iv),
        .in_ready  (d_ir),
        .a_in      (d_a),
        .b_in      (d_b),
        .c_in      (d_ci),
        .sub_in    (d_sb),
        .out_valid (d_ov),
        .out_ready (d_or),
        .sum_out   (d_s),
        .c_out     (d_co),
        .ovf_out   (d_ovf)
    );

    task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb,
                        input logic [7:0] es, input logic eco, input logic eovf);
        @(negedge clk);
        d_a = a; d_b = b; d_ci = ci; d_sb = sb; d_iv = 1'b1; d_or = 1'b1;
        @(negedge clk);
        d_iv = 1'b0;
        #1 chk({tag, "_early"}, 64'(d_ov), 64'(0));
        @(negedge clk);
        #1;
        chk({tag, "_vld"}, 64'(d_ov), 64'(1));
        chk({tag, "_sum"}, 64'(d_s), 64'(es));
        chk({tag, "_cout"}, 64'(d_co), 64'(eco));
        chk({tag, "_ovf"}, 64'(d_ovf), 64'(eovf));
    endtask

    initial begin
        int         nb, nr;
        bit         prev_stall, saw_block;
        logic [7:0] prev_s;

        repeat (2) @(negedge clk);
        chk("rst_vld", 64'(d_ov), 64'(0));
        chk("rst_sum", 64'(d_s), 64'(0));
        chk("rst_cout", 64'(d_co), 64'(0));
        chk("rst_ovf", 64'(d_ovf), 64'(0));
        d_rst = 1'b0;
        @(negedge clk);
        #1 chk("rst_inready", 64'(d_ir), 64'(1));

        run1("carry_x",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run1("ovf_pos",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run1("ovf_neg",  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run1("sub_brw",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run1("sub_nbrw", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        run1("add_cin",  8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);

        // Backpressure: five back-to-back beats, sink stalls for cycles 3..6.
        nb = 0; nr = 0; prev_stall = 1'b0; saw_block = 1'b0; prev_s = '0;
        d_ci = 1'b0; d_sb = 1'b0;
        for (int n = 0; n < 40 && nr < 5; n++) begin
            @(negedge clk);
            d_iv = (nb < 5);
            d_a  = 8'(nb + 1);
            d_b  = 8'h10;
            d_or = !(n >= 3 && n <= 6);
            #1;
            if (prev_stall) chk("bp_hold", 64'(d_s), 64'(prev_s));
            if (!d_ir) saw_block = 1'b1;
            if (d_iv && d_ir) nb++;
            if (d_ov && d_or) begin
                chk("bp_order", 64'(d_s), 64'(8'h11 + 8'(nr)));
                nr++;
            end
            prev_stall = d_ov && !d_or;
            prev_s     = d_s;
        end
        d_iv = 1'b0;
        chk("bp_count", 64'(nr), 64'(5));
        chk("bp_inready_drop", 64'(saw_block), 64'(1));
        @(negedge clk);
        #1 chk("bp_nodup", 64'(d_ov), 64'(0));

        // Reset with two beats in flight.
        @(negedge clk);
        d_iv = 1'b1; d_a = 8'h30; d_b = 8'h01; d_or = 1'b0;
        @(negedge clk);
        d_a = 8'h40;
        @(negedge clk);
        d_iv = 1'b0; d_rst = 1'b1;
        @(negedge clk);
        d_rst = 1'b0; d_or = 1'b1;
        #1 chk("rst_flush", 64'(d_ov), 64'(0));
        repeat (3) begin
            @(negedge clk);
            #1 chk("rst_nostale", 64'(d_ov), 64'(0));
        end
        @(negedge clk);
        d_iv = 1'b1; d_a = 8'h21; d_b = 8'h02;
        @(negedge clk);
        d_iv = 1'b0;
        #1 chk("rst_next_early", 64'(d_ov), 64'(0));
        @(negedge clk);
        #1;
        chk("rst_next_vld", 64'(d_ov), 64'(1));
        chk("rst_next_sum", 64'(d_s), 64'(8'h23));

        done_cnt++;
    end

    // ---------------- randomized sweep at WIDTH=32 ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 4 : 8;

        logic        rst_s = 1'b1, iv_s = 1'b0, ir_s, ci_s = 1'b0, sb_s = 1'b0;
        logic        or_s = 1'b0, ov_s, co_s, ovf_s;
        logic [31:0] a_s = '0, b_s = '0, s_s;

        pipe_adder #(.WIDTH(32), .STAGES(ST)) u_dut (
            .clk       (clk),
            .rst       (rst_s),
            .in_valid  (iv_s),
            .in_ready  (ir_s),
            .a_in      (a_s),
            .b_in      (b_s),
            .c_in      (ci_s),
            .sub_in    (sb_s),
            .out_valid (ov_s),
            .out_ready (or_s),
            .sum_out   (s_s),
            .c_out     (co_s),
            .ovf_out   (ovf_s)
        );

        initial begin
            logic [33:0] q_exp[$];
            int          q_cyc[$];
            int          q_stl[$];
            logic [33:0] e;
            logic [32:0] full;
            logic [31:0] bp;
            logic        eo;
            int          acc, cyc, stl, c0, s0;
            bit          seen;

            acc = 0; cyc = 0; stl = 0; seen = 1'b0;
            repeat (3) @(negedge clk);
            rst_s = 1'b0;
            while ((acc < 1000 || q_exp.size() > 0) && cyc < 20000) begin
                @(negedge clk);
                iv_s = (acc < 1000) && ($urandom_range(0, 3) != 0);
                a_s  = $urandom;
                b_s  = $urandom;
                ci_s = 1'($urandom_range(0, 1));
                sb_s = 1'($urandom_range(0, 1));
                or_s = ($urandom_range(0, 9) < 7);
                #1;
                if (ov_s && !seen) begin
                    if (q_exp.size() == 0) begin
                        chk($sformatf("sw%0d_spurious", ST), 64'(1), 64'(0));
                    end else begin
                        chk($sformatf("sw%0d_latency", ST), 64'(cyc),
                            64'(q_cyc[0] + ST + (stl - q_stl[0])));
                        seen = 1'b1;
                    end
                end
                if (ov_s && or_s && q_exp.size() > 0) begin
                    e  = q_exp.pop_front();
                    c0 = q_cyc.pop_front();
                    s0 = q_stl.pop_front();
                    chk($sformatf("sw%0d_sum", ST), 64'(s_s), 64'(e[31:0]));
                    chk($sformatf("sw%0d_cout", ST), 64'(co_s), 64'(e[32]));
                    chk($sformatf("sw%0d_ovf", ST), 64'(ovf_s), 64'(e[33]));
                    seen = 1'b0;
                end
                if (iv_s && ir_s) begin
                    bp   = sb_s ? ~b_s : b_s;
                    full = {1'b0, a_s} + {1'b0, bp} + 33'(sb_s ? 1'b1 : ci_s);
                    eo   = (a_s[31] == bp[31]) && (full[31] != a_s[31]);
                    q_exp.push_back({eo, full});
                    q_cyc.push_back(cyc);
                    q_stl.push_back(stl);
                    acc++;
                end
                if (ov_s && !or_s) stl++;
                cyc++;
            end
            chk($sformatf("sw%0d_drained", ST), 64'(q_exp.size()), 64'(0));
            chk($sformatf("sw%0d_accepted", ST), 64'(acc), 64'(1000));
            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 30000 && done_cnt < 4; t++) @(negedge clk);
        chk("all_done", 64'(done_cnt), 64'(4));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the single-bit half adder.
- Adds or subtracts two WIDTH-bit operands across STAGES carry-segmented pipeline stages, with carry-in, carry-out and signed overflow.
- Valid/ready handshake on both sides, with full backpressure.
- Used as the shared arithmetic datapath primitive in the top-level ALU/accumulator paths.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES
STAGES, 4, number of pipeline stages; each stage resolves CHUNK = WIDTH/STAGES bits; legal range 1..WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a_in  input  WIDTH  operand A (two's complement or unsigned)
b_in  input  WIDTH  operand B
c_in  input  1  carry-in; ignored when sub_in=1
sub_in  input  1  0: A+B+c_in; 1: A-B (A + ~B + 1)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum_out  output  WIDTH  result, modulo 2^WIDTH
c_out  output  1  carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
ovf_out  output  1  signed overflow: operand MSBs after B-inversion are equal and differ from sum MSB

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all stage valid bits are 0; out_valid=0, sum_out=0, c_out=0, ovf_out=0. in_ready=1 in the cycle after reset releases.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational). All stages shift together when adv=1 and hold when adv=0. Bubbles are not compressed.
- Accept: a beat is captured when in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Input conditioning at capture:
  - B' = sub_in ? ~b_in : b_in
  - cin' = sub_in ? 1 : c_in
- Stage k (0..STAGES-1):
  - adds chunk k of A and B' plus the carry registered by stage k-1 (cin' for k=0)
  - registers the CHUNK-bit partial sum and the chunk carry
  - unprocessed upper chunks of A/B' and completed lower sum chunks travel alongside, delayed in skew registers
- Latency: exactly STAGES cycles from accept to out_valid with no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Output stage:
  - c_out = carry of the final chunk
  - ovf_out = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]); the operand MSBs needed for this are carried through the pipeline
- Output stability: sum_out, c_out and ovf_out stay stable while out_valid=1 & out_ready=0.
- STAGES=1: single registered adder, latency 1.
- Wrap-around: arithmetic is mod 2^WIDTH; no saturation.
- Reset mid-operation: all in-flight beats are discarded; no partial result appears after rst.
- Simultaneous accept with an output handshake while full: allowed, since adv=1 when out_ready=1; no beat is lost or duplicated.
- No combinational path from a_in/b_in to any output. The only combinational path is out_ready -> in_ready.

Decomposition:
- Shared package pipe_adder_pkg:
  - function for CHUNK width (WIDTH/STAGES)
  - elaboration-time check constant/assertion that WIDTH % STAGES == 0
  - op encoding constants OP_ADD=0, OP_SUB=1
- Sub-module pa_chunk: combinational CHUNK-bit adder with carry in/out, built as a ripple of full-adder cells. Instantiated once per stage via generate.
- Top level holds the stage registers, skew registers, valid chain and handshake.

Test Plan (WIDTH=8, STAGES=2 unless noted):
1. Add with carry propagating across the chunk boundary: a=0xFF, b=0x01, c_in=0, sub=0 -> after 2 cycles sum=0x00, c_out=1, ovf=0.
2. Signed overflow: a=0x7F, b=0x01 -> sum=0x80, c_out=0, ovf=1. Also a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf=1.
3. Subtract with borrow: a=0x05, b=0x07, sub=1, c_in=1 (ignored) -> sum=0xFE, c_out=0, ovf=0. Also a=0x07, b=0x05 -> sum=0x02, c_out=1.
4. Backpressure: 5 back-to-back beats (a=i, b=0x10, i=1..5), out_ready low for cycles 3-6.
   - in_ready drops once the pipe and output are full.
   - Outputs 0x11..0x15 arrive in order, each exactly once; sum_out is held stable during the stall.
5. Reset mid-stream: rst asserted one cycle with 2 beats in flight -> out_valid=0 next cycle; no stale result ever appears; the next accepted beat emerges after 2 cycles.
6. Parameter sweep against a reference model, 1000 random beats with random out_ready:
   - STAGES=1, 4, 8 at WIDTH=32
   - results match {c_out, sum} = A + B' + cin' and ovf per the rule above
   - latency equals STAGES when unstalled
